// File: rtl/ad760x_pkg.sv
// Shared types and helpers for the AD7606-family parallel-bus controller.
package ad760x_pkg;

  typedef enum logic [2:0] {
    ADC_RST,
    IDLE,
    CONV,
    WAIT_BHI,
    WAIT_BLO,
    RD_LO,
    RD_HI
  } state_t;

  typedef enum logic [2:0] {
    OS_NONE = 3'b000,
    OS_X2   = 3'b001,
    OS_X4   = 3'b010,
    OS_X8   = 3'b011,
    OS_X16  = 3'b100,
    OS_X32  = 3'b101,
    OS_X64  = 3'b110,
    OS_RSVD = 3'b111
  } os_t;

  localparam int CH_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The reserved OS code is mapped to the highest legal ratio.
  function automatic logic [2:0] os_clamp(input logic [2:0] os);
    return (os == OS_RSVD) ? OS_X64 : os;
  endfunction

endpackage

// File: rtl/ad760x_sync_2ff.sv
// Double-flop synchronizer for asynchronous inputs (used for ADC BUSY).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ad760x_ctrl.sv
// AD7606-family controller: ADC reset, CONVST, BUSY wait, parallel readout.
// Optional build macro AD760X_FRSTDATA_CHECK_EN enables FRSTDATA framing checks.
module ad760x_ctrl
  import ad760x_pkg::*;
#(
  parameter int NCHAN    = 8,
  parameter int DW       = 16,
  parameter int T_RST    = 4,
  parameter int T_CONV   = 2,
  parameter int T_RDLO   = 2,
  parameter int T_RDHI   = 2,
  parameter int BUSY_TMO = 4096
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          start_i,
  input  logic [2:0]    os_sel_i,
  output logic [2:0]    os_o,
  output logic          adc_reset_o,
  output logic          convst_n_o,
  output logic          cs_n_o,
  output logic          rd_n_o,
  input  logic          busy_i,
  input  logic          frstdata_i,
  input  logic [DW-1:0] db_i,
  output logic [DW-1:0] data_o,
  output logic [2:0]    chan_o,
  output logic          valid_o,
  output logic          last_o,
  output logic          idle_o,
  output logic          err_o
);

  localparam int PH_MAX = max_int(max_int(T_RST, T_CONV), max_int(T_RDLO, T_RDHI));
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(BUSY_TMO + 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCHAN - 1);

  state_t state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [2:0]       os_q, os_d;
  logic             adc_reset_q, adc_reset_d;
  logic             convst_n_q, convst_n_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic [DW-1:0]    data_q, data_d;
  logic [2:0]       chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             idle_q, idle_d;
  logic             err_q, err_d;
  logic             busy_sync;
  logic             frst_bad;

  sync_2ff #(.W(1)) u_busy_sync (
    .clk_i (clk_i),
    .rst_ni(reset_n_i),
    .d_i   (busy_i),
    .q_o   (busy_sync)
  );

`ifdef AD760X_FRSTDATA_CHECK_EN
  // FRSTDATA must flag exactly the first word of each frame.
  assign frst_bad = (frstdata_i != (ch_q == '0));
`else
  logic unused_frstdata;
  assign unused_frstdata = frstdata_i;
  assign frst_bad        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q + PH_W'(1);
    tmo_cnt_d = tmo_cnt_q;
    ch_d      = ch_q;
    os_d      = os_q;
    data_d    = data_q;
    chan_d    = chan_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ADC_RST: begin
        if (ph_cnt_q == PH_W'(T_RST - 1)) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
        end
      end
      IDLE: begin
        ph_cnt_d = '0;
        if (start_i) begin
          os_d      = os_clamp(os_sel_i);
          err_d     = (os_sel_i == OS_RSVD);
          tmo_cnt_d = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        if (ph_cnt_q == PH_W'(T_CONV - 1)) begin
          state_d  = WAIT_BHI;
          ph_cnt_d = '0;
        end
      end
      WAIT_BHI: begin
        ph_cnt_d  = '0;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_cnt_q == TMO_W'(BUSY_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = ADC_RST;
        end else if (busy_sync) begin
          state_d = WAIT_BLO;
        end
      end
      WAIT_BLO: begin
        ph_cnt_d  = '0;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_cnt_q == TMO_W'(BUSY_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = ADC_RST;
        end else if (!busy_sync) begin
          ch_d    = '0;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        // The bus has settled by the last low cycle; capture there.
        if (ph_cnt_q == PH_W'(T_RDLO - 1)) begin
          data_d   = db_i;
          chan_d   = ch_q;
          valid_d  = 1'b1;
          last_d   = (ch_q == CH_LAST);
          if (frst_bad) err_d = 1'b1;
          ph_cnt_d = '0;
          state_d  = RD_HI;
        end
      end
      RD_HI: begin
        if (ph_cnt_q == PH_W'(T_RDHI - 1)) begin
          ph_cnt_d = '0;
          if (ch_q == CH_LAST) begin
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = RD_LO;
          end
        end
      end
      default: begin
        ph_cnt_d = '0;
        state_d  = ADC_RST;
      end
    endcase

    // Pin strobes are registered decodes of the next state, so they never glitch.
    adc_reset_d = (state_d == ADC_RST);
    convst_n_d  = (state_d != CONV);
    cs_n_d      = !((state_d == RD_LO) || (state_d == RD_HI));
    rd_n_d      = (state_d != RD_LO);
    idle_d      = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ADC_RST;
      ph_cnt_q    <= '0;
      tmo_cnt_q   <= '0;
      ch_q        <= '0;
      os_q        <= OS_NONE;
      adc_reset_q <= 1'b1;
      convst_n_q  <= 1'b1;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      data_q      <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      idle_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ch_q        <= ch_d;
      os_q        <= os_d;
      adc_reset_q <= adc_reset_d;
      convst_n_q  <= convst_n_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  assign os_o        = os_q;
  assign adc_reset_o = adc_reset_q;
  assign convst_n_o  = convst_n_q;
  assign cs_n_o      = cs_n_q;
  assign rd_n_o      = rd_n_q;
  assign data_o      = data_q;
  assign chan_o      = chan_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign idle_o      = idle_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ad760x_ctrl.sv
// Scoreboard bench for ad760x_ctrl with a behavioural AD7606 model.
module tb_ad760x_ctrl;

  localparam int NCHAN    = 8;
  localparam int DW       = 16;
  localparam int T_RST    = 4;
  localparam int BUSY_TMO = 64;
`ifdef AD760X_FRSTDATA_CHECK_EN
  localparam logic EXP_FRST_ERR = 1'b1;
`else
  localparam logic EXP_FRST_ERR = 1'b0;
`endif

  logic          clk;
  logic          reset_n_i;
  logic          start_i;
  logic [2:0]    os_sel_i;
  logic [2:0]    os_o;
  logic          adc_reset_o;
  logic          convst_n_o;
  logic          cs_n_o;
  logic          rd_n_o;
  logic          busy_i;
  logic          frstdata_i;
  logic [DW-1:0] db_i;
  logic [DW-1:0] data_o;
  logic [2:0]    chan_o;
  logic          valid_o;
  logic          last_o;
  logic          idle_o;
  logic          err_o;

  ad760x_ctrl #(
    .NCHAN(NCHAN), .DW(DW), .T_RST(T_RST), .T_CONV(2),
    .T_RDLO(2), .T_RDHI(2), .BUSY_TMO(BUSY_TMO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .os_sel_i(os_sel_i),
    .os_o(os_o), .adc_reset_o(adc_reset_o), .convst_n_o(convst_n_o),
    .cs_n_o(cs_n_o), .rd_n_o(rd_n_o), .busy_i(busy_i), .frstdata_i(frstdata_i),
    .db_i(db_i), .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o),
    .last_o(last_o), .idle_o(idle_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    chan;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            vcount = 0;
  bit            busy_stuck = 1'b0;
  bit            pattern    = 1'b0;
  bit            inject     = 1'b0;
  logic [DW-1:0] frame[NCHAN];
  int            widx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ADC model: each CONVST starts a frame; the expected stream is queued at that point.
  initial begin
    busy_i = 1'b0;
    forever begin
      @(negedge convst_n_o);
      widx = 0;
      for (int c = 0; c < NCHAN; c++)
        frame[c] = pattern ? DW'(32'h1000 + c) : DW'($urandom);
      if (!busy_stuck) begin
        for (int c = 0; c < NCHAN; c++)
          exp_q.push_back('{frame[c], 3'(c), (c == NCHAN - 1)});
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 busy_i = 1'b1;
        repeat ($urandom_range(5, 30)) @(posedge clk);
        #1 busy_i = 1'b0;
      end
    end
  end

  // The ADC presents the next word when RD falls.
  initial begin
    db_i       = '0;
    frstdata_i = 1'b0;
    forever begin
      @(negedge rd_n_o);
      db_i       = frame[(widx < NCHAN) ? widx : 0];
      frstdata_i = (widx == 0) ^ (inject && widx == 2);
      widx++;
    end
  end

  // Monitor: pop and compare on every output strobe.
  always @(negedge clk) begin
    if (reset_n_i && valid_o) begin
      vcount++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got chan %0d data %0h want no output", chan_o, data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", 32'(data_o), 32'(e.data));
        chk("chan", 32'(chan_o), 32'(e.chan));
        chk("last", 32'(last_o), 32'(e.last));
        chk("cs_n_during_read", 32'(cs_n_o), 32'd0);
      end
    end
  end

  task automatic wait_idle(input logic lvl, input int lim, input string nm);
    int n = 0;
    while (idle_o !== lvl && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (idle_o !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: idle_o stuck at %0b want %0b", nm, idle_o, lvl);
    end
  endtask

  task automatic measure_adc_reset(output int n);
    n = 0;
    while (adc_reset_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic measure_idle(output int n);
    n = 0;
    while (idle_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_frame(input logic [2:0] os_in, input logic [2:0] exp_os,
                           input logic exp_err, input string nm);
    int vbase;
    vbase = vcount;
    wait_idle(1'b1, 2000, {nm, "_pre_idle"});
    os_sel_i = os_in;
    start_i  = 1'b1;
    wait_idle(1'b0, 20, {nm, "_accept"});
    start_i  = 1'b0;
    chk({nm, "_os"}, 32'(os_o), 32'(exp_os));
    chk({nm, "_err_at_start"}, 32'(err_o), 32'(exp_err));
    wait_idle(1'b1, 2000, {nm, "_done"});
    chk({nm, "_nwords"}, 32'(vcount - vbase), 32'(NCHAN));
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int vbase;
    int nfall;
    logic prev;
    reset_n_i = 1'b0;
    start_i   = 1'b0;
    os_sel_i  = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_adc_reset", 32'(adc_reset_o), 32'd1);
    chk("rst_convst_n", 32'(convst_n_o), 32'd1);
    chk("rst_cs_n", 32'(cs_n_o), 32'd1);
    chk("rst_rd_n", 32'(rd_n_o), 32'd1);
    chk("rst_os", 32'(os_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_chan", 32'(chan_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // Power-up: ADC held in reset for T_RST cycles.
    @(negedge clk) reset_n_i = 1'b1;
    measure_adc_reset(n);
    chk("powerup_rst_len", 32'(n), 32'(T_RST));
    chk("powerup_idle", 32'(idle_o), 32'd1);
    chk("powerup_strobes", 32'({convst_n_o, cs_n_o, rd_n_o}), 32'b111);

    // Known data pattern frame.
    pattern = 1'b1;
    run_frame(3'b000, 3'b000, 1'b0, "pattern");
    pattern = 1'b0;

    // Back-to-back frames with start held high.
    vbase    = vcount;
    os_sel_i = 3'b011;
    start_i  = 1'b1;
    wait_idle(1'b0, 20, "b2b_accept");
    chk("b2b_os", 32'(os_o), 32'b011);
    for (int f = 0; f < 2; f++) begin
      wait_idle(1'b1, 2000, "b2b_frame_end");
      measure_idle(n);
      chk("b2b_idle_len", 32'(n), 32'd1);
    end
    start_i = 1'b0;
    wait_idle(1'b1, 2000, "b2b_done");
    chk("b2b_nwords", 32'(vcount - vbase), 32'(3 * NCHAN));
    repeat (3) @(posedge clk);
    #1 chk("b2b_stays_idle", 32'(idle_o), 32'd1);

    // Random data, random legal OS codes.
    for (int i = 0; i < 3; i++) begin
      logic [2:0] os_r;
      os_r = 3'($urandom_range(0, 6));
      run_frame(os_r, os_r, 1'b0, "random");
    end

    // Reserved OS code clamps and flags; next start clears the flag.
    run_frame(3'b111, 3'b110, 1'b1, "os_rsvd");
    chk("os_rsvd_err_kept", 32'(err_o), 32'd1);
    run_frame(3'b010, 3'b010, 1'b0, "os_rsvd_clear");

    // BUSY never rises: timeout, ADC re-reset, no output.
    busy_stuck = 1'b1;
    vbase      = vcount;
    os_sel_i   = 3'b001;
    start_i    = 1'b1;
    wait_idle(1'b0, 20, "tmo_accept");
    start_i = 1'b0;
    n = 0;
    while (!convst_n_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (!err_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(BUSY_TMO));
    chk("tmo_adc_reset", 32'(adc_reset_o), 32'd1);
    chk("tmo_strobes", 32'({convst_n_o, cs_n_o, rd_n_o}), 32'b111);
    measure_adc_reset(n);
    chk("tmo_rst_len", 32'(n), 32'(T_RST));
    chk("tmo_no_valid", 32'(vcount - vbase), 32'd0);
    chk("tmo_err_held", 32'(err_o), 32'd1);
    busy_stuck = 1'b0;
    run_frame(3'b000, 3'b000, 1'b0, "tmo_recover");

    // FRSTDATA asserted on the wrong word.
    inject = 1'b1;
    run_frame(3'b100, 3'b100, 1'b0, "frst");
    chk("frst_err", 32'(err_o), 32'(EXP_FRST_ERR));
    inject = 1'b0;
    run_frame(3'b000, 3'b000, 1'b0, "frst_clear");
    chk("frst_clear_err", 32'(err_o), 32'd0);

    // Reset asserted during the third read-low phase.
    vbase    = vcount;
    os_sel_i = 3'b000;
    start_i  = 1'b1;
    wait_idle(1'b0, 20, "mid_accept");
    start_i = 1'b0;
    nfall = 0;
    prev  = rd_n_o;
    n     = 0;
    while (nfall < 3 && n < 2000) begin
      @(posedge clk); #1;
      if (prev && !rd_n_o) nfall++;
      prev = rd_n_o;
      n++;
    end
    chk("mid_reached_rd3", 32'(nfall), 32'd3);
    reset_n_i = 1'b0;
    #1;
    chk("mid_cs_n", 32'(cs_n_o), 32'd1);
    chk("mid_rd_n", 32'(rd_n_o), 32'd1);
    chk("mid_valid", 32'(valid_o), 32'd0);
    chk("mid_adc_reset", 32'(adc_reset_o), 32'd1);
    chk("mid_idle", 32'(idle_o), 32'd0);
    chk("mid_partial_words", 32'(vcount - vbase), 32'd2);
    exp_q.delete();
    @(negedge clk) reset_n_i = 1'b1;
    measure_adc_reset(n);
    chk("mid_restart_rst_len", 32'(n), 32'(T_RST));
    chk("mid_restart_idle", 32'(idle_o), 32'd1);
    run_frame(3'b101, 3'b101, 1'b0, "mid_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running want finished");
    $fatal(1, "global timeout");
  end

endmodule
